// File: rtl/voting_machine_nc.sv
// voting_machine_nc: debounced N-candidate voter with saturating counts, running total, winner/tie (VOTE_LOCK_EN locks voting after first result mode)
module voting_machine_nc #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mode,
    input  logic [NUM_CAND-1:0]                 button,
    output logic [CNT_W-1:0]                    vote_result,
    output logic                                result_valid,
    output logic                                vote_ack,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total_votes,
    output logic [$clog2(NUM_CAND)-1:0]         winner,
    output logic                                tie
);
    localparam int IW = $clog2(NUM_CAND);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
    state_t state, state_d;
    logic [NUM_CAND-1:0] btn_m, btn;
    logic mode_m, md, one_hot, commit, accept, vote_en, tie_d;
    logic [IW-1:0] idx, idx_d, low_idx, win_d;
    logic [HW-1:0] hold, hold_d;
    logic [CNT_W-1:0] max_d;
    logic [CNT_W-1:0] count [NUM_CAND];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            btn_m  <= '0;
            btn    <= '0;
            mode_m <= 1'b0;
            md     <= 1'b0;
        end else begin
            btn_m  <= button;
            btn    <= btn_m;
            mode_m <= mode;
            md     <= mode_m;
        end
`ifdef VOTE_LOCK_EN
    logic locked;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) locked <= 1'b0;
        else if (md) locked <= 1'b1;
    assign vote_en = !md && !locked;
`else
    assign vote_en = !md;
`endif
    assign one_hot = (btn != '0) && ((btn & (btn - 1'b1)) == '0);
    assign accept  = commit && (count[idx] != '1);
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) if (btn[i]) low_idx = IW'(i);
    end
    always_comb begin
        state_d = state;
        idx_d   = idx;
        hold_d  = hold;
        commit  = 1'b0;
        case (state)
            IDLE: if (vote_en && one_hot) begin
                state_d = HOLD;
                idx_d   = low_idx;
                hold_d  = HW'(1);
            end
            HOLD: if (!md && btn == (NUM_CAND'(1) << idx)) begin
                hold_d = hold + 1'b1;
                if (hold_d == HW'(HOLD_CYCLES)) begin
                    commit  = 1'b1;
                    state_d = WAIT_REL;
                end
            end else state_d = (btn == '0) ? IDLE : WAIT_REL;
            WAIT_REL: state_d = (btn == '0) ? IDLE : WAIT_REL;
            default: state_d = IDLE;
        endcase
    end
    // lowest index wins on equal counts because only a strictly larger count replaces it
    always_comb begin
        max_d = '0;
        win_d = '0;
        tie_d = 1'b0;
        for (int i = 0; i < NUM_CAND; i++)
            if (count[i] > max_d) begin
                max_d = count[i];
                win_d = IW'(i);
            end
        for (int i = 0; i < NUM_CAND; i++)
            if (count[i] == max_d && IW'(i) != win_d && max_d != '0) tie_d = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            hold         <= '0;
            vote_ack     <= 1'b0;
            total_votes  <= '0;
            vote_result  <= '0;
            result_valid <= 1'b0;
            winner       <= '0;
            tie          <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            hold         <= hold_d;
            vote_ack     <= accept;
            vote_result  <= (md && btn != '0) ? count[low_idx] : '0;
            result_valid <= md && (btn != '0);
            winner       <= win_d;
            tie          <= tie_d;
            if (accept) begin
                count[idx]  <= count[idx] + 1'b1;
                total_votes <= total_votes + 1'b1;
            end
        end
endmodule

// File: tb/tb_voting_machine_nc.sv
// tb_voting_machine_nc: directed checks of voting, debounce, saturation, tie and reset behaviour
module tb_voting_machine_nc;
    logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, sat_mode = 1'b0;
    logic [3:0] button = '0, sat_button = '0;
    logic [7:0] vote_result;
    logic [1:0] sat_result;
    logic result_valid, vote_ack, tie, sat_valid, sat_ack, sat_tie;
    logic [9:0] total_votes;
    logic [3:0] sat_total;
    logic [1:0] winner, sat_winner;
    int checks = 0, errors = 0, acks = 0, sat_acks = 0;
    int exp_total, exp_c0;

    voting_machine_nc u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .button(button),
        .vote_result(vote_result), .result_valid(result_valid), .vote_ack(vote_ack),
        .total_votes(total_votes), .winner(winner), .tie(tie)
    );
    voting_machine_nc #(.NUM_CAND(4), .CNT_W(2), .HOLD_CYCLES(10)) u_sat (
        .clk(clk), .rst_n(rst_n), .mode(sat_mode), .button(sat_button),
        .vote_result(sat_result), .result_valid(sat_valid), .vote_ack(sat_ack),
        .total_votes(sat_total), .winner(sat_winner), .tie(sat_tie)
    );

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (vote_ack) acks++;
        if (sat_ack) sat_acks++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] b, input int n);
        button = b;
        repeat (n) @(negedge clk);
        button = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic sat_press(input logic [3:0] b, input int n);
        sat_button = b;
        repeat (n) @(negedge clk);
        sat_button = '0;
        repeat (20) @(negedge clk);
    endtask

    // result appears exactly one cycle after the synchronized button/mode
    task automatic read(input int c, input int exp);
        mode = 1'b1;
        button = 4'(1 << c);
        repeat (2) @(negedge clk);
        chk($sformatf("valid_early%0d", c), 32'(result_valid), 0);
        @(negedge clk);
        chk($sformatf("valid%0d", c), 32'(result_valid), 1);
        chk($sformatf("result%0d", c), 32'(vote_result), exp);
        button = '0;
        mode = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        button = 4'hf;
        sat_button = 4'hf;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(vote_result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_ack", 32'(vote_ack), 0);
        chk("rst_total", 32'(total_votes), 0);
        chk("rst_winner", 32'(winner), 0);
        chk("rst_tie", 32'(tie), 0);
        button = '0;
        sat_button = '0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_total", 32'(total_votes), 0);
        chk("idle_acks", acks, 0);

        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4 - c; k++) press(4'(1 << c), 30);
        chk("acks10", acks, 10);
        chk("total10", 32'(total_votes), 10);
        chk("winner0", 32'(winner), 0);
        chk("tie0", 32'(tie), 0);
        for (int c = 0; c < 4; c++) read(c, 4 - c);
        mode = 1'b1;
        repeat (5) @(negedge clk);
        chk("nobtn_valid", 32'(result_valid), 0);
        chk("nobtn_result", 32'(vote_result), 0);
        mode = 1'b0;
        repeat (5) @(negedge clk);

        press(4'b0001, 5);
        chk("short_press", acks, 10);
        press(4'b0011, 30);
        chk("multi_hot", acks, 10);
        press(4'b0100, 1000);
        chk("long_hold", acks, 11);
        button = 4'b0001;
        repeat (5) @(negedge clk);
        press(4'b0010, 30);
        chk("mid_switch", acks, 11);
        press(4'b0010, 30);
        chk("repress", acks, 12);
        chk("total12", 32'(total_votes), 12);
        chk("winner_t", 32'(winner), 0);
        chk("tie_t", 32'(tie), 1);

        for (int k = 0; k < 4; k++) sat_press(4'b0100, 30);
        chk("sat_acks", sat_acks, 3);
        chk("sat_total", 32'(sat_total), 3);
        chk("sat_winner", 32'(sat_winner), 2);
        sat_mode = 1'b1;
        sat_button = 4'b0100;
        repeat (4) @(negedge clk);
        chk("sat_count", 32'(sat_result), 3);
        sat_mode = 1'b0;
        sat_button = '0;

        button = 4'b0001;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        button = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midhold_total", 32'(total_votes), 0);
        chk("midhold_acks", acks, 12);
        chk("midhold_winner", 32'(winner), 0);

        press(4'b0010, 30);
        press(4'b0010, 30);
        press(4'b1000, 30);
        press(4'b1000, 30);
        chk("tie_total", 32'(total_votes), 4);
        chk("tie_winner", 32'(winner), 1);
        chk("tie_flag", 32'(tie), 1);
        press(4'b1000, 30);
        chk("lead_winner", 32'(winner), 3);
        chk("lead_tie", 32'(tie), 0);

        press(4'b0001, 30);
        mode = 1'b1;
        repeat (5) @(negedge clk);
        mode = 1'b0;
        repeat (5) @(negedge clk);
        press(4'b0001, 30);
`ifdef VOTE_LOCK_EN
        exp_total = 6;
        exp_c0 = 1;
`else
        exp_total = 7;
        exp_c0 = 2;
`endif
        chk("lock_total", 32'(total_votes), exp_total);
        chk("lock_acks", acks, 12 + exp_total);
        read(0, exp_c0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/voting_machine_nc.md
# voting_machine_nc

Parametrised N-candidate voting machine, the successor to the fixed four-button voter. It absorbs button debouncing, vote logging and mode control in one block. It adds configurable candidate count and counter width, saturating counts, a running total, and registered winner/tie detection. It sits between the raw candidate push-buttons and the result display driver.

## Interface
- NUM_CAND, 4: number of candidates/buttons (2..16)
- CNT_W, 8: per-candidate count width
- HOLD_CYCLES, 10: consecutive synchronized cycles a button must be held to register one vote (≥2)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- mode  in  1  0 = voting, 1 = result display
- button  in  NUM_CAND  one bit per candidate, bit i = candidate i
- vote_result  out  CNT_W  count of the candidate selected in result mode
- result_valid  out  1  vote_result holds a selected count
- vote_ack  out  1  one-cycle pulse per accepted vote
- total_votes  out  CNT_W+$clog2(NUM_CAND)  sum of all accepted votes
- winner  out  $clog2(NUM_CAND)  index of leading candidate
- tie  out  1  two or more candidates share a non-zero maximum

## Operation
- button and mode pass through a 2-flop synchronizer; all logic below uses synchronized values.
- Vote FSM states: IDLE, HOLD, WAIT_REL.
  - IDLE: mode=0 and button exactly one-hot -> latch index, hold counter=1, go HOLD. Zero or multi-hot -> stay.
  - HOLD: button equal to latched one-hot -> counter+1. On the sample that makes counter==HOLD_CYCLES: commit vote, go WAIT_REL. Button==0 -> IDLE, no vote. Any other non-zero value, or mode=1 -> WAIT_REL, no vote.
  - WAIT_REL: stay until button==0, then IDLE. A held button therefore yields exactly one vote.
- Commit: count[i]+1 and total_votes+1, vote_ack=1. If count[i] is already all-ones, the vote is rejected: count and total unchanged, vote_ack stays 0.
- Result mode (mode=1): vote_result = count of the lowest set button bit, result_valid=1. With button==0: vote_result=0, result_valid=0. In voting mode: vote_result=0, result_valid=0.
- winner = lowest index holding the maximum count. tie=1 only if ≥2 candidates equal the maximum and the maximum >0. All counts zero: winner=0, tie=0.
- Reset at any time, including mid-HOLD, returns the FSM to IDLE and clears all counts with no partial vote.

## Timing
- Reset values: vote_result=0, result_valid=0, vote_ack=0, total_votes=0, winner=0, tie=0; counts 0, FSM IDLE.
- Synchronizer latency is 2 cycles. A one-hot press is committed HOLD_CYCLES cycles after its first synchronized sample.
- vote_ack, count[i] and total_votes update on the same edge. winner/tie update one cycle later.
- vote_result/result_valid are registered, 1 cycle after synchronized button/mode.
- Minimum raw press length for a vote is HOLD_CYCLES cycles. Shorter presses are discarded.

## Configuration
- VOTE_LOCK_EN defined: the first synchronized mode=1 sets a sticky lock. Afterwards the FSM stays in IDLE regardless of mode, so no further votes are accepted until reset. Result mode works normally.
- VOTE_LOCK_EN undefined: returning to mode=0 re-enables voting; counts persist.

## Test plan
- Reset held low for 3 cycles with buttons active -> all outputs 0. Release; outputs stay 0 with no button.
- NUM_CAND=4, HOLD_CYCLES=10: cast 4/3/2/1 votes on candidates 0..3 (30-cycle presses, 20-cycle gaps) -> 10 vote_ack pulses, total_votes=10, winner=0, tie=0. Result mode with buttons 0001/0010/0100/1000 -> vote_result 4,3,2,1, each one cycle after the synchronized button.
- 5-cycle press -> no vote. Press 0011 -> no vote. Hold 0100 for 1000 cycles -> exactly one vote_ack. Mid-HOLD switch 0001->0010 -> no vote until release and re-press.
- Two votes each on candidates 1 and 3 only -> winner=1, tie=1. One more on 3 -> winner=3, tie=0.
- CNT_W=2: four presses on candidate 2 -> count 3, only 3 vote_acks, total_votes=3.
- Reset asserted mid-HOLD -> counts 0, FSM IDLE. VOTE_LOCK_EN: vote, mode 1 then 0, press -> count unchanged. Without the macro -> count+1.
